ifu_pc_ctrl: RTL

- Fetch-side PC controller that consumes the D-stage branch/jump decision and redirects instruction fetch.
- Sits between the D-stage branch comparator / decoder and the instruction memory address port.
- Holds the F-stage PC and the D-stage PC, and applies stall freezing and MIPS single delay-slot semantics.
- Flags illegal fetch targets for the exception path.

---
 rtl/ifu_pc_ctrl.sv | 59 +++++
 1 files changed

// File: rtl/ifu_pc_ctrl.sv
// ifu_pc_ctrl: fetch PC controller with delay-slot redirect, stall freeze and illegal-target flag.
// Define IFU_BRANCH_COUNT_EN to add the br_cnt / br_taken_cnt branch counters.
module ifu_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [15:0] br_imm,
  input  logic        j_valid,
  input  logic [25:0] j_index,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic        pc_err,
`ifdef IFU_BRANCH_COUNT_EN
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt,
`endif
  output logic        redirect
);
  logic [31:0] npc;
  logic        bad;
  logic        br_go;
  assign br_go    = br_valid & br_taken;
  assign redirect = jr_valid | j_valid | br_go;
  // pc_f already points at the delay slot, so branch offsets are relative to it
  always_comb
    npc = jr_valid ? jr_target :
          j_valid  ? {pc_d[31:28], j_index, 2'b00} :
          br_go    ? pc_f + {{14{br_imm[15]}}, br_imm, 2'b00} :
                     pc_f + 32'd4;
  assign bad = (|npc[1:0]) | (npc < IM_BASE) | (npc > IM_LIMIT);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc_f   <= RESET_PC;
      pc_d   <= RESET_PC;
      pc_err <= 1'b0;
    end else if (!stall) begin
      pc_d   <= pc_f;
      pc_f   <= npc;
      pc_err <= bad;
    end
`ifdef IFU_BRANCH_COUNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (!stall) begin
      br_cnt       <= br_cnt + {31'd0, br_valid};
      br_taken_cnt <= br_taken_cnt + {31'd0, br_go};
    end
`endif
endmodule
